// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
// The register file has no reset, so the arbiter's zero sweep is the only way it gets cleared.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback-side bus of the arbiter: two requesters, clear pulse, and the register-file write port.
// slave is the arbiter's view; master is the writeback stage / register file view.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);

  logic              clear_req;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              init_done;

  modport slave (
    input  clear_req,
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready,
    output rf_reg_write, rf_write_reg, rf_write_data,
    output init_done
  );

  modport master (
    output clear_req,
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready,
    input  rf_reg_write, rf_write_reg, rf_write_data,
    input  init_done
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Single write port owner for the register file: zero sweep after reset/clear, then
// A-priority arbitration between two writeback requesters with a starvation guard for B.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REGS     = regfile_pkg::NUM_REGS,
  parameter int ADDR_W       = regfile_pkg::ADDR_W,
  parameter int DATA_W       = regfile_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  io
);

  // cnt must reach NUM_REGS itself: that extra value is the idle cycle before RUN.
  localparam int CNT_W = $clog2(NUM_REGS + 1);
  localparam int STV_W = 4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              rf_reg_write_q, rf_reg_write_d;
  logic [ADDR_W-1:0] rf_write_reg_q, rf_write_reg_d;
  logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;

  logic a_ready, b_ready;
  logic a_acc, b_acc;
  logic starve_override;

  assign starve_override = (starve_q == STV_W'(STARVE_LIMIT));

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state_q == ST_RUN && !io.clear_req) begin
      if (starve_override) begin
        b_ready = 1'b1;
      end else begin
        a_ready = 1'b1;
        b_ready = !io.a_valid;
      end
    end
  end

  assign a_acc = io.a_valid & a_ready;
  assign b_acc = io.b_valid & b_ready;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rf_reg_write_d  = 1'b0;
    rf_write_reg_d  = rf_write_reg_q;
    rf_write_data_d = rf_write_data_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(NUM_REGS)) begin
          state_d = ST_RUN;
        end else begin
          rf_reg_write_d  = 1'b1;
          rf_write_reg_d  = ADDR_W'(cnt_q);
          rf_write_data_d = '0;
          cnt_d           = cnt_q + 1'b1;
        end
      end
      default: begin
        if (io.clear_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (b_acc) begin
          // Address 0 completes the handshake but never writes, keeping $zero at 0.
          rf_reg_write_d  = (io.b_addr != ADDR_W'(ZERO_REG));
          rf_write_reg_d  = io.b_addr;
          rf_write_data_d = io.b_data;
        end else if (a_acc) begin
          rf_reg_write_d  = (io.a_addr != ADDR_W'(ZERO_REG));
          rf_write_reg_d  = io.a_addr;
          rf_write_data_d = io.a_data;
        end
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!io.b_valid || b_acc) begin
      starve_d = '0;
    end else if (state_q == ST_RUN && !starve_override) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_INIT;
      cnt_q           <= '0;
      starve_q        <= '0;
      rf_reg_write_q  <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      starve_q        <= starve_d;
      rf_reg_write_q  <= rf_reg_write_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
    end
  end

  assign io.a_ready       = a_ready;
  assign io.b_ready       = b_ready;
  assign io.rf_reg_write  = rf_reg_write_q;
  assign io.rf_write_reg  = rf_write_reg_q;
  assign io.rf_write_data = rf_write_data_q;
  assign io.init_done     = (state_q == ST_RUN);

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Owns the single write port of the 32×32 register file. After reset, and on request, it sweeps every register to zero, because the register file has no reset of its own. In normal operation it arbitrates two writeback requesters onto the port: A is the ALU writeback and has priority; B is the load/multicycle writeback and is protected by a starvation guard. It sits between the writeback stage and `register_file`, driving that block's `reg_write`, `write_reg` and `write_data`.

## Interface
- `NUM_REGS`, 32: registers swept during init.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive blocked cycles of B before B is forced to win; legal range 1..15.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clear_req`  in  1: one-cycle pulse that re-runs the zero sweep; honoured only in RUN.
- `a_valid`  in  1: requester A has a write.
- `a_addr`  in  ADDR_W: requester A destination register.
- `a_data`  in  DATA_W: requester A write data.
- `a_ready`  out  1: A accepted this cycle when `a_valid & a_ready`.
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as A, for requester B.
- `rf_reg_write`  out  1: register file write strobe.
- `rf_write_reg`  out  ADDR_W: register file write address.
- `rf_write_data`  out  DATA_W: register file write data.
- `init_done`  out  1: high when in RUN.

## Operation
- FSM states:
  - INIT: sweep counter `cnt` runs 0..NUM_REGS-1, writing 0 to register `cnt`.
  - RUN: arbitration.
- Transitions:
  - INIT→RUN after the write of NUM_REGS-1 is issued.
  - RUN→INIT on `clear_req`. `cnt` is reset to 0 on entry.
  - `rst` forces INIT from any state.
- `clear_req` during INIT is ignored.
- In INIT: `a_ready = b_ready = 0`.
- In RUN with `clear_req = 1`: `a_ready = b_ready = 0`, and nothing is accepted that cycle.
- Arbitration in RUN (ready outputs are combinational from the valids, `clear_req`, the state and the starvation counter):
  - Normal: `a_ready = 1`; `b_ready = !a_valid`.
  - Override, when `starve_cnt == STARVE_LIMIT`: `b_ready = 1`, `a_ready = 0`.
- Starvation counter:
  - Increments in each RUN cycle where `b_valid & !b_ready`.
  - Clears on B acceptance or whenever `b_valid = 0`.
  - Saturates at STARVE_LIMIT.
  - Reset value 0.
- Accepted write is registered into the `rf_*` outputs on the same edge. `rf_reg_write` is high for exactly one cycle per accepted write.
- Writes to address 0 in RUN are accepted (handshake completes) but `rf_reg_write` stays 0. This keeps $zero at 0.
- At most one write per cycle, so no simultaneous-write case reaches the register file.

## Timing
- Reset values:
  - `rf_reg_write = 0`, `rf_write_reg = 0`, `rf_write_data = 0`.
  - `init_done = 0`, `a_ready = 0`, `b_ready = 0`.
  - State INIT, `cnt = 0`, `starve_cnt = 0`.
- Init sweep:
  - Rising edges 1..NUM_REGS after `rst` falls present a write of 0 to registers 0..NUM_REGS-1 (`rf_reg_write = 1`).
  - Edge NUM_REGS+1 enters RUN: `init_done = 1`, `rf_reg_write = 0`.
  - Total is 33 cycles for NUM_REGS = 32.
- Latency:
  - Handshake on edge N → `rf_*` valid in cycle N..N+1 → register file captures on edge N+1.
  - A read of that register reflects the new value after edge N+1.
- Clear:
  - `clear_req` sampled on edge N drops `init_done` and starts the sweep.
  - The write of register 0 is presented after edge N+1.
- Reset mid-sweep restarts at register 0 once `rst` falls; the partial sweep is discarded.

## Structure
- Shared package `regfile_pkg` holds:
  - the ADDR_W/DATA_W/NUM_REGS constants;
  - the state enum `{ST_INIT, ST_RUN}`, 1 bit;
  - the `ZERO_REG = 0` constant.
- Single module with no sub-module. The starvation counter and the sweep counter are inline registers.

## Test plan
- Reset release: 33 cycles with writes to regs 0..31 of value 0, then `init_done = 1`. All `register_file` reads return 0x00000000.
- RUN, A-only write, `a_addr = 5`, `a_data = 0xDEADBEEF`: `a_ready = 1`, one `rf_reg_write` pulse on the next cycle, and register 5 reads 0xDEADBEEF after the following edge.
- A and B valid continuously: A is accepted for 4 cycles, B is forced through on the 5th (`b_ready = 1`, `a_ready = 0`), then A resumes. The pattern repeats every 5 cycles.
- B write to address 0 with data 0x1234: B is accepted, `rf_reg_write` stays 0, and register 0 still reads 0.
- Clear in RUN with registers holding data: `clear_req` pulse drops `init_done`, both readys are 0 for 33 cycles, and all registers read 0 afterwards. A `clear_req` issued during that sweep has no effect.
- Assert `rst` at sweep step 10 for 2 cycles: outputs return to their reset values immediately, and the sweep restarts at register 0 after release.
